// File: rtl/axi_read_scheduler_if.sv
// Per-master cache read ports plus the shared AXI read address/data channel.
// The scheduler connects through 'master'; the memory and cache side use 'slave'.
interface axi_read_scheduler_if #(
    parameter int MASTERS    = 9,
    parameter int ADDR_WIDTH = 26,
    parameter int DATA_WIDTH = 32
);
    logic [MASTERS-1:0]            m_arvalid;
    logic [MASTERS*ADDR_WIDTH-1:0] m_araddr;
    logic [MASTERS*4-1:0]          m_arlen;
    logic [MASTERS-1:0]            m_arready;
    logic [MASTERS-1:0]            m_rvalid;
    logic [MASTERS-1:0]            m_rlast;
    logic [DATA_WIDTH-1:0]         m_rdata;
    logic [MASTERS-1:0]            m_rready;

    logic                          ARVALID;
    logic [3:0]                    ARID;
    logic [3:0]                    ARLEN;
    logic [ADDR_WIDTH-1:0]         ARADDR;
    logic                          ARREADY;
    logic                          RVALID;
    logic                          RLAST;
    logic [3:0]                    RID;
    logic [DATA_WIDTH-1:0]         RDATA;
    logic                          RREADY;

    modport master (
        input  m_arvalid, m_araddr, m_arlen, m_rready,
               ARREADY, RVALID, RLAST, RID, RDATA,
        output m_arready, m_rvalid, m_rlast, m_rdata,
               ARVALID, ARID, ARLEN, ARADDR, RREADY
    );

    modport slave (
        output m_arvalid, m_araddr, m_arlen, m_rready,
               ARREADY, RVALID, RLAST, RID, RDATA,
        input  m_arready, m_rvalid, m_rlast, m_rdata,
               ARVALID, ARID, ARLEN, ARADDR, RREADY
    );
endinterface

// File: rtl/axi_read_scheduler.sv
// Round-robin scheduler sharing one AXI read channel among cache read requesters.
// One burst is in flight at a time; returned beats are steered to the granted master.
module axi_read_scheduler #(
    parameter int MASTERS    = 9,
    parameter int ADDR_WIDTH = 26,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    axi_read_scheduler_if.master  bus,
    output logic                  busy,
    output logic                  protocol_err
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t                state, state_next;
    logic [3:0]            grant;
    logic [3:0]            last_grant;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [3:0]            req_len;
    logic [3:0]            beat_cnt;

    logic [4:0]            cand;
    logic [3:0]            pick;
    logic                  pick_found;
    logic                  rid_ok;
    logic                  rready;
    logic                  beat_acc;

    // Search starts just above the previous winner so every requester gets a turn.
    always_comb begin
        cand       = '0;
        pick       = '0;
        pick_found = 1'b0;
        for (int k = 1; k <= MASTERS; k++) begin
            cand = 5'(last_grant) + 5'(k);
            if (cand >= 5'(MASTERS)) cand = cand - 5'(MASTERS);
            if (!pick_found && bus.m_arvalid[cand[3:0]]) begin
                pick       = cand[3:0];
                pick_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: registered state uses non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        // NOTE: every output gets a default before the case so no path can
        // leave a signal unassigned and infer a latch.
        state_next    = state;
        bus.ARVALID   = 1'b0;
        bus.ARID      = '0;
        bus.ARLEN     = '0;
        bus.ARADDR    = '0;
        bus.m_arready = '0;
        bus.m_rvalid  = '0;
        bus.m_rlast   = '0;
        bus.m_rdata   = '0;
        rid_ok        = (bus.RID == grant);
        rready        = 1'b0;
        beat_acc      = 1'b0;
        case (state)
            IDLE: if (pick_found) state_next = ADDR;
            ADDR: begin
                bus.ARVALID = 1'b1;
                bus.ARID    = grant;
                bus.ARLEN   = req_len;
                bus.ARADDR  = req_addr;
                if (bus.ARREADY) begin
                    bus.m_arready[grant] = 1'b1;
                    state_next           = DATA;
                end
            end
            DATA: begin
                // Beats tagged for another ID are drained so the channel cannot lock up.
                rready              = rid_ok ? bus.m_rready[grant] : 1'b1;
                bus.m_rvalid[grant] = bus.RVALID && rid_ok;
                bus.m_rlast[grant]  = bus.RLAST && rid_ok;
                bus.m_rdata         = bus.RDATA;
                beat_acc            = bus.RVALID && rready;
                if (beat_acc && bus.RLAST) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        bus.RREADY = rready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant        <= '0;
            last_grant   <= 4'(MASTERS - 1);
            req_addr     <= '0;
            req_len      <= '0;
            beat_cnt     <= '0;
            protocol_err <= 1'b0;
        end else begin
            case (state)
                IDLE: if (pick_found) begin
                    grant    <= pick;
                    req_addr <= bus.m_araddr[int'(pick)*ADDR_WIDTH +: ADDR_WIDTH];
                    req_len  <= bus.m_arlen[int'(pick)*4 +: 4];
                end
                ADDR: if (bus.ARREADY) beat_cnt <= '0;
                DATA: if (beat_acc) begin
                    if (!rid_ok) protocol_err <= 1'b1;
                    if (bus.RLAST) begin
                        if (beat_cnt != req_len) protocol_err <= 1'b1;
                        last_grant <= grant;
                    end else if (beat_cnt == req_len) begin
                        protocol_err <= 1'b1;
                    end
                    // Saturate at the burst length rather than wrapping on overrun.
                    if (beat_cnt != req_len) beat_cnt <= beat_cnt + 4'd1;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);
endmodule

// File: tb/tb_axi_read_scheduler.sv
// Self-checking bench for axi_read_scheduler: directed scenarios plus a randomized
// run scored against a round-robin / burst reference model.
module tb_axi_read_scheduler;
    localparam int M  = 9;
    localparam int AW = 26;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    logic protocol_err;
    int   total = 0;
    int   bad   = 0;

    axi_read_scheduler_if #(.MASTERS(M), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    axi_read_scheduler #(.MASTERS(M), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .busy         (busy),
        .protocol_err (protocol_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    function automatic logic [M-1:0] onehot(input int i);
        onehot = '0;
        if (i >= 0 && i < M) onehot[i] = 1'b1;
    endfunction

    // Round-robin rule: first requester strictly after 'last', wrapping.
    function automatic int rr_pick(input bit [M-1:0] req, input int last);
        for (int k = 1; k <= M; k++) begin
            int i;
            i = (last + k) % M;
            if (req[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [DW-1:0] beat_data(input logic [AW-1:0] a, input int b);
        return DW'({6'h0, a}) ^ DW'(32'h9E37_79B9 * (b + 1));
    endfunction

    task automatic clear_inputs();
        bus.m_arvalid = '0;
        bus.m_araddr  = '0;
        bus.m_arlen   = '0;
        bus.m_rready  = '0;
        bus.ARREADY   = 1'b0;
        bus.RVALID    = 1'b0;
        bus.RLAST     = 1'b0;
        bus.RID       = '0;
        bus.RDATA     = '0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        clear_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic grant_burst(input int id, input logic [AW-1:0] a, input logic [3:0] len,
                               input string tag);
        bit ok = 1'b0;
        for (int c = 0; c < 10 && !ok; c++) begin
            @(negedge clk);
            bus.m_arvalid             = onehot(id);
            bus.m_araddr[id*AW +: AW] = a;
            bus.m_arlen[id*4 +: 4]    = len;
            bus.ARREADY               = 1'b1;
            #1;
            ok = bus.ARVALID;
        end
        total++;
        if (!ok || bus.ARID !== 4'(id) || bus.m_arready !== onehot(id)) begin
            bad++;
            $display("FAIL %s_grant: arvalid=%0b arid=%0d arready=%0h, want arid=%0d arready=%0h",
                     tag, ok, bus.ARID, bus.m_arready, id, onehot(id));
        end
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got=%0b want=0", busy); end
        total++; if (protocol_err !== 1'b0) begin bad++; $display("FAIL reset_err: got=%0b want=0", protocol_err); end
        total++; if (bus.ARVALID !== 1'b0 || bus.RREADY !== 1'b0) begin bad++; $display("FAIL reset_axi: arvalid=%0b rready=%0b want 0 0", bus.ARVALID, bus.RREADY); end
        total++; if (bus.m_arready !== '0 || bus.m_rvalid !== '0 || bus.m_rlast !== '0) begin bad++; $display("FAIL reset_m: arready=%0h rvalid=%0h rlast=%0h want 0", bus.m_arready, bus.m_rvalid, bus.m_rlast); end
    endtask

    task automatic test_single();
        apply_reset();
        @(negedge clk);
        bus.m_arvalid[3]         = 1'b1;
        bus.m_araddr[3*AW +: AW] = 26'h0001000;
        bus.m_arlen[3*4 +: 4]    = 4'd3;
        bus.ARREADY              = 1'b1;
        #1;
        total++; if (bus.ARVALID !== 1'b0) begin bad++; $display("FAIL single_latency: arvalid=%0b want=0 in request cycle", bus.ARVALID); end
        @(negedge clk); #1;
        total++; if (bus.ARVALID !== 1'b1 || bus.ARID !== 4'd3) begin bad++; $display("FAIL single_ar: arvalid=%0b arid=%0d want 1 3", bus.ARVALID, bus.ARID); end
        total++; if (bus.ARADDR !== 26'h0001000 || bus.ARLEN !== 4'd3) begin bad++; $display("FAIL single_addr: araddr=%0h arlen=%0d want 1000 3", bus.ARADDR, bus.ARLEN); end
        total++; if (bus.m_arready !== onehot(3)) begin bad++; $display("FAIL single_arready: got=%0h want=%0h", bus.m_arready, onehot(3)); end
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            bus.m_arvalid = '0;
            bus.ARREADY   = 1'b0;
            bus.m_rready  = onehot(3);
            bus.RVALID    = 1'b1;
            bus.RID       = 4'd3;
            bus.RLAST     = (b == 3);
            bus.RDATA     = 32'hC0DE_0000 + DW'(b);
            #1;
            total++; if (bus.m_rvalid !== onehot(3) || bus.RREADY !== 1'b1) begin bad++; $display("FAIL single_beat%0d: rvalid=%0h rready=%0b want %0h 1", b, bus.m_rvalid, bus.RREADY, onehot(3)); end
            total++; if (bus.m_rdata !== 32'hC0DE_0000 + DW'(b) || bus.m_rlast !== (b == 3 ? onehot(3) : '0)) begin bad++; $display("FAIL single_data%0d: rdata=%0h rlast=%0h", b, bus.m_rdata, bus.m_rlast); end
            if (b == 0) begin
                total++; if (bus.m_arready !== '0) begin bad++; $display("FAIL single_pulse: arready=%0h want 0", bus.m_arready); end
            end
        end
        @(negedge clk);
        bus.RVALID = 1'b0;
        #1;
        total++; if (busy !== 1'b0 || protocol_err !== 1'b0) begin bad++; $display("FAIL single_end: busy=%0b err=%0b want 0 0", busy, protocol_err); end
    endtask

    task automatic test_fairness();
        int         exp_id;
        bit         ok;
        logic [3:0] seen;
        apply_reset();
        for (int g = 0; g < 10; g++) begin
            exp_id = g % M;
            ok     = 1'b0;
            for (int c = 0; c < 10 && !ok; c++) begin
                @(negedge clk);
                bus.m_arvalid = '1;
                bus.ARREADY   = 1'b1;
                bus.RVALID    = 1'b0;
                bus.m_rready  = '1;
                #1;
                ok = bus.ARVALID;
            end
            total++;
            if (!ok) begin
                bad++; $display("FAIL fair_timeout: grant %0d never issued", g);
            end else begin
                seen = bus.ARID;
                total++; if (seen !== 4'(exp_id) || bus.m_arready !== onehot(exp_id)) begin bad++; $display("FAIL fair_order%0d: arid=%0d arready=%0h want %0d", g, seen, bus.m_arready, exp_id); end
                @(negedge clk);
                bus.RVALID = 1'b1;
                bus.RLAST  = 1'b1;
                bus.RID    = seen;
                bus.RDATA  = DW'(g);
                #1;
                total++; if (bus.m_rvalid !== onehot(exp_id)) begin bad++; $display("FAIL fair_beat%0d: rvalid=%0h want %0h", g, bus.m_rvalid, onehot(exp_id)); end
            end
        end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_backpressure();
        logic [AW-1:0] a;
        int            beat;
        bit            rr_bit;
        apply_reset();
        a = AW'($urandom);
        @(negedge clk);
        bus.m_arvalid            = onehot(8);
        bus.m_araddr[8*AW +: AW] = a;
        bus.m_arlen[8*4 +: 4]    = 4'd3;
        #1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            total++; if (bus.ARVALID !== 1'b1 || bus.ARADDR !== a || bus.m_arready !== '0) begin bad++; $display("FAIL bp_hold%0d: arvalid=%0b araddr=%0h arready=%0h want 1 %0h 0", c, bus.ARVALID, bus.ARADDR, bus.m_arready, a); end
        end
        @(negedge clk);
        bus.ARREADY = 1'b1;
        #1;
        total++; if (bus.m_arready !== onehot(8) || bus.ARID !== 4'd8) begin bad++; $display("FAIL bp_accept: arready=%0h arid=%0d want %0h 8", bus.m_arready, bus.ARID, onehot(8)); end
        beat = 0;
        for (int cyc = 0; cyc < 40 && beat < 4; cyc++) begin
            @(negedge clk);
            rr_bit        = 1'(cyc & 1);
            bus.ARREADY   = 1'b0;
            bus.m_arvalid = '0;
            bus.m_rready  = rr_bit ? onehot(8) : '0;
            bus.RVALID    = 1'b1;
            bus.RID       = 4'd8;
            bus.RLAST     = (beat == 3);
            bus.RDATA     = beat_data(a, beat);
            #1;
            total++; if (bus.RREADY !== rr_bit || bus.m_rvalid !== onehot(8)) begin bad++; $display("FAIL bp_rready: rready=%0b rvalid=%0h want %0b %0h", bus.RREADY, bus.m_rvalid, rr_bit, onehot(8)); end
            total++; if (bus.m_rdata !== beat_data(a, beat)) begin bad++; $display("FAIL bp_data%0d: got=%0h want=%0h", beat, bus.m_rdata, beat_data(a, beat)); end
            if (rr_bit) beat++;
        end
        @(negedge clk);
        bus.RVALID = 1'b0;
        #1;
        total++; if (busy !== 1'b0 || protocol_err !== 1'b0) begin bad++; $display("FAIL bp_end: busy=%0b err=%0b want 0 0 after 4 beats", busy, protocol_err); end
    endtask

    task automatic test_rid_mismatch();
        apply_reset();
        grant_burst(2, 26'h00ABC0, 4'd1, "rid");
        @(negedge clk);
        bus.m_arvalid = '0;
        bus.ARREADY   = 1'b0;
        bus.m_rready  = '0;
        bus.RVALID    = 1'b1;
        bus.RID       = 4'd5;
        bus.RLAST     = 1'b0;
        bus.RDATA     = 32'hBAD0_0005;
        #1;
        total++; if (bus.RREADY !== 1'b1) begin bad++; $display("FAIL rid_drain: rready=%0b want=1", bus.RREADY); end
        total++; if (bus.m_rvalid !== '0 || bus.m_rlast !== '0) begin bad++; $display("FAIL rid_forward: rvalid=%0h rlast=%0h want 0", bus.m_rvalid, bus.m_rlast); end
        @(negedge clk);
        bus.RID      = 4'd2;
        bus.RLAST    = 1'b1;
        bus.m_rready = onehot(2);
        #1;
        total++; if (protocol_err !== 1'b1) begin bad++; $display("FAIL rid_err: got=%0b want=1", protocol_err); end
        total++; if (bus.m_rvalid !== onehot(2) || bus.m_rlast !== onehot(2)) begin bad++; $display("FAIL rid_good_beat: rvalid=%0h rlast=%0h want %0h", bus.m_rvalid, bus.m_rlast, onehot(2)); end
        @(negedge clk);
        bus.RVALID = 1'b0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rid_idle: busy=%0b want=0", busy); end
        grant_burst(2, 26'h00ABD0, 4'd0, "rid2");
        @(negedge clk);
        bus.m_arvalid = '0;
        bus.ARREADY   = 1'b0;
        bus.RVALID    = 1'b1;
        bus.RLAST     = 1'b1;
        bus.RID       = 4'd2;
        #1;
        @(negedge clk);
        bus.RVALID = 1'b0;
        #1;
        total++; if (protocol_err !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL rid_sticky: err=%0b busy=%0b want 1 0", protocol_err, busy); end
    endtask

    task automatic test_rlast_early();
        apply_reset();
        grant_burst(1, 26'h0002000, 4'd3, "rlast");
        for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            bus.m_arvalid = '0;
            bus.ARREADY   = 1'b0;
            bus.m_rready  = onehot(1);
            bus.RVALID    = 1'b1;
            bus.RID       = 4'd1;
            bus.RLAST     = (b == 1);
            #1;
            total++; if (protocol_err !== 1'b0 || bus.m_rvalid !== onehot(1)) begin bad++; $display("FAIL rlast_beat%0d: err=%0b rvalid=%0h want 0 %0h", b, protocol_err, bus.m_rvalid, onehot(1)); end
        end
        @(negedge clk);
        bus.RVALID = 1'b0;
        #1;
        total++; if (protocol_err !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL rlast_end: err=%0b busy=%0b want 1 0", protocol_err, busy); end
    endtask

    task automatic test_reset_in_data();
        apply_reset();
        grant_burst(4, 26'h0003000, 4'd3, "rstdata");
        @(negedge clk);
        bus.m_arvalid = '0;
        bus.ARREADY   = 1'b0;
        bus.m_rready  = onehot(4);
        bus.RVALID    = 1'b1;
        bus.RID       = 4'd4;
        bus.RLAST     = 1'b0;
        bus.RDATA     = 32'h1234_5678;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++; if (busy !== 1'b0 || bus.ARVALID !== 1'b0 || bus.RREADY !== 1'b0) begin bad++; $display("FAIL rstdata_ctrl: busy=%0b arvalid=%0b rready=%0b want 0", busy, bus.ARVALID, bus.RREADY); end
        total++; if (bus.m_rvalid !== '0 || bus.m_rlast !== '0 || bus.m_rdata !== '0 || bus.m_arready !== '0) begin bad++; $display("FAIL rstdata_m: rvalid=%0h rlast=%0h rdata=%0h arready=%0h want 0", bus.m_rvalid, bus.m_rlast, bus.m_rdata, bus.m_arready); end
        @(negedge clk);
        bus.RVALID    = 1'b0;
        bus.m_arvalid = '1;
        #1;
        @(negedge clk); #1;
        total++; if (bus.ARVALID !== 1'b1 || bus.ARID !== 4'd0) begin bad++; $display("FAIL rstdata_first: arvalid=%0b arid=%0d want 1 0", bus.ARVALID, bus.ARID); end
    endtask

    task automatic test_random();
        bit [M-1:0]    pend, prev_pend;
        logic [AW-1:0] p_addr [M];
        logic [3:0]    p_len  [M];
        logic [AW-1:0] c_addr;
        logic [3:0]    c_len;
        int            model_last, cur, exp_id, done, beat;
        bit            ar_seen, in_data, acc_ar, acc_r;
        apply_reset();
        pend = '0; prev_pend = '0; model_last = M - 1; cur = 0; done = 0; beat = 0;
        ar_seen = 1'b0; in_data = 1'b0; c_addr = '0; c_len = '0;
        for (int i = 0; i < M; i++) begin p_addr[i] = '0; p_len[i] = '0; end
        for (int cyc = 0; cyc < 4000 && done < 60; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < M; i++) begin
                if (!pend[i] && $urandom_range(0, 3) == 0) begin
                    pend[i]   = 1'b1;
                    p_addr[i] = AW'($urandom);
                    p_len[i]  = 4'($urandom_range(0, 3));
                end
                bus.m_araddr[i*AW +: AW] = p_addr[i];
                bus.m_arlen[i*4 +: 4]    = p_len[i];
            end
            bus.m_arvalid = pend;
            bus.ARREADY   = 1'($urandom_range(0, 1));
            bus.m_rready  = M'($urandom);
            bus.RVALID    = in_data && ($urandom_range(0, 3) != 0);
            bus.RID       = in_data ? 4'(cur) : 4'd0;
            bus.RLAST     = in_data && (beat == int'(c_len));
            bus.RDATA     = beat_data(c_addr, beat);
            #1;
            if (bus.ARVALID && !ar_seen) begin
                exp_id  = rr_pick(prev_pend, model_last);
                ar_seen = 1'b1;
                if (exp_id < 0) begin
                    total++; bad++;
                    $display("FAIL rand_spurious_ar: arid=%0d with no request pending", bus.ARID);
                    exp_id = int'(bus.ARID) % M;
                end
                cur    = exp_id;
                c_addr = p_addr[cur];
                c_len  = p_len[cur];
            end
            if (ar_seen) begin
                total++; if (bus.ARVALID !== 1'b1 || bus.ARID !== 4'(cur) || bus.ARADDR !== c_addr || bus.ARLEN !== c_len) begin bad++; $display("FAIL rand_ar: arvalid=%0b arid=%0d araddr=%0h arlen=%0d want 1 %0d %0h %0d", bus.ARVALID, bus.ARID, bus.ARADDR, bus.ARLEN, cur, c_addr, c_len); end
            end
            acc_ar = ar_seen && bus.ARREADY;
            total++; if (bus.m_arready !== (acc_ar ? onehot(cur) : '0)) begin bad++; $display("FAIL rand_arready: got=%0h want=%0h", bus.m_arready, acc_ar ? onehot(cur) : '0); end
            total++; if (bus.m_rvalid !== ((in_data && bus.RVALID) ? onehot(cur) : '0) || bus.RREADY !== (in_data && bus.m_rready[cur])) begin bad++; $display("FAIL rand_r: rvalid=%0h rready=%0b cur=%0d in_data=%0b", bus.m_rvalid, bus.RREADY, cur, in_data); end
            acc_r = in_data && bus.RVALID && bus.m_rready[cur];
            if (acc_r) begin
                total++; if (bus.m_rdata !== beat_data(c_addr, beat) || bus.m_rlast !== (bus.RLAST ? onehot(cur) : '0)) begin bad++; $display("FAIL rand_beat: rdata=%0h rlast=%0h want %0h last=%0b", bus.m_rdata, bus.m_rlast, beat_data(c_addr, beat), bus.RLAST); end
            end
            prev_pend = pend;
            if (acc_r) begin
                beat++;
                if (beat > int'(c_len)) begin
                    in_data    = 1'b0;
                    model_last = cur;
                    done++;
                    beat = 0;
                end
            end
            if (acc_ar) begin
                pend[cur] = 1'b0;
                ar_seen   = 1'b0;
                in_data   = 1'b1;
                beat      = 0;
            end
        end
        total++; if (done < 60) begin bad++; $display("FAIL rand_timeout: bursts done=%0d want 60", done); end
        total++; if (protocol_err !== 1'b0) begin bad++; $display("FAIL rand_err: got=%0b want=0", protocol_err); end
        @(negedge clk);
        clear_inputs();
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_rid_mismatch();
        test_rlast_early();
        test_reset_in_data();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
